// File: rtl/charlieplex_scroller.sv
// Scrolling column display: buffers 5-bit columns in a FIFO and shifts one column into
// a 7-column window every TicksPerStep clocks. Each new window is written as 5 rows over Wishbone.
module charlieplex_scroller #(
  parameter int TicksPerStep = 1000000,
  parameter int Depth        = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     col_valid_i,
  output logic                     col_ready_o,
  input  logic [4:0]               col_data_i,
  output logic                     wb_we_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  output logic [3:0]               wb_adr_o,
  output logic [7:0]               wb_dat_o,
  input  logic [7:0]               wb_dat_i,
  output logic [$clog2(Depth):0]   fifo_level_o
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TicksPerStep);

  typedef enum logic [1:0] {INIT, IDLE, WRITE} state_e;

  state_e          state_q, state_d;
  logic [4:0]      mem [Depth];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [CW-1:0]   cnt_q;
  logic            tick, pending_q, step_req;
  logic            push, pop, empty;
  logic [6:0][4:0] win_q;
  logic [2:0]      row_q;
  logic            last_row, stb_q, ack_ok;
  logic [6:0]      row_bits;
  logic            unused_dat;

  assign unused_dat  = ^wb_dat_i;
  assign empty       = (level == '0);
  assign col_ready_o = (level != LW'(Depth));
  assign push        = col_valid_i && col_ready_o;
  assign tick        = (cnt_q == CW'(TicksPerStep - 1));
  assign step_req    = tick || pending_q;
  assign pop         = (state_q == IDLE) && step_req && !empty;
  assign last_row    = (row_q == 3'd4);
  assign ack_ok      = stb_q && wb_ack_i;
  assign fifo_level_o = level;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= col_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A step that lands mid-burst is remembered once; further ticks fold into the same flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      if (state_q == IDLE) begin
        if (step_req) pending_q <= 1'b0;
      end else if (tick) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q   <= '0;
      row_q   <= '0;
      stb_q   <= 1'b0;
      state_q <= INIT;
    end else begin
      if (pop) win_q <= {mem[rd_ptr], win_q[6:1]};
      if (ack_ok) row_q <= last_row ? 3'd0 : row_q + 3'd1;
      stb_q   <= (state_d != IDLE);
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT, WRITE: if (ack_ok && last_row) state_d = IDLE;
      IDLE:        if (pop) state_d = WRITE;
      default:     state_d = INIT;
    endcase
  end

  for (genvar c = 0; c < 7; c++) begin : g_row
    assign row_bits[c] = win_q[c][row_q];
  end

  // Strobe is registered so reset forces it low immediately even though INIT is the reset state.
  always_comb begin
    wb_stb_o = stb_q;
    wb_we_o  = stb_q;
    wb_adr_o = stb_q ? {1'b0, row_q} : 4'd0;
    wb_dat_o = stb_q ? {1'b0, row_bits} : 8'd0;
  end

endmodule

// File: tb/tb_charlieplex_scroller.sv
// Scoreboard bench: each accepted column queues its 5 expected row writes; a monitor
// pops and compares on every acknowledged Wishbone write.
module tb_charlieplex_scroller;
  localparam int TPS   = 7;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       col_valid, col_ready;
  logic [4:0] col_data;
  logic       we, stb, ack;
  logic [3:0] adr;
  logic [7:0] dat, dat_i;
  logic [3:0] level;

  int n_chk = 0, n_fail = 0;
  int wait_cfg = 0, wcnt = 0;
  logic stall = 1'b0, chk_hold = 1'b1;
  logic [11:0] exp_q[$];
  logic [4:0]  mw [7];
  logic [7:0]  last_dat [5];
  int hold = 0, low = 0, last_gap = 0;
  logic unstable = 1'b0;
  logic [3:0] p_adr;
  logic [7:0] p_dat;

  charlieplex_scroller #(.TicksPerStep(TPS), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .col_valid_i(col_valid), .col_ready_o(col_ready),
    .col_data_i(col_data), .wb_we_o(we), .wb_stb_o(stb), .wb_ack_i(ack),
    .wb_adr_o(adr), .wb_dat_o(dat), .wb_dat_i(dat_i), .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  // Peripheral: acks after wait_cfg wait cycles unless stalled.
  assign ack = stb && !stall && (wcnt == wait_cfg);
  always @(posedge clk) wcnt <= (!stb || ack || stall) ? 0 : wcnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tfail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic model_push(input logic [4:0] d);
    logic [7:0] v;
    for (int k = 0; k < 6; k++) mw[k] = mw[k+1];
    mw[6] = d;
    for (int r = 0; r < 5; r++) begin
      v = 8'h00;
      for (int c = 0; c < 7; c++) v[c] = mw[c][r];
      exp_q.push_back({4'(r), v});
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < 7; k++) mw[k] = 5'h00;
    for (int r = 0; r < 5; r++) exp_q.push_back({4'(r), 8'h00});
  endtask

  task automatic push(input logic [4:0] d);
    int t = 0;
    @(negedge clk);
    col_valid = 1'b1;
    col_data  = d;
    while (!col_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) tfail("push");
    @(posedge clk);
    model_push(d);
  endtask

  task automatic release_col();
    @(negedge clk);
    col_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int t = 0;
    while ((exp_q.size() != 0 || stb) && t < bound) begin @(negedge clk); t++; end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic idle_quiet(input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin @(negedge clk); if (stb) seen = 1'b1; end
    chk("idle_quiet", seen, 0);
  endtask

  // Monitor: compare every acknowledged write and track hold time / stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0; unstable = 1'b0; low = 0;
    end else if (stb) begin
      if (hold > 0 && (adr != p_adr || dat != p_dat)) unstable = 1'b1;
      p_adr = adr; p_dat = dat; hold++;
      if (low > 0) last_gap = low;
      low = 0;
      if (ack) begin
        chk("we", we, 1);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write actual adr=%0h dat=%0h required none", adr, dat);
        end else chk("write", {adr, dat}, exp_q.pop_front());
        if (chk_hold) chk("hold", unstable ? 999 : hold, wait_cfg + 1);
        if (adr < 5) last_dat[adr] = dat;
        hold = 0; unstable = 1'b0;
      end
    end else begin
      hold = 0; unstable = 1'b0; low++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] diag [7];
    logic [7:0] diag_rows [5];
    logic [4:0] fill [8];
    int t;
    diag = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h00};
    diag_rows = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30};
    fill = '{5'h03, 5'h05, 5'h06, 5'h09, 5'h0C, 5'h11, 5'h12, 5'h14};
    rst_n = 1'b0; col_valid = 1'b0; col_data = 5'h00; dat_i = 8'hA5;
    for (int r = 0; r < 5; r++) last_dat[r] = 8'hFF;

    // Reset state and INIT blanking burst
    repeat (3) @(negedge clk);
    chk("rst_stb", stb, 0); chk("rst_we", we, 0); chk("rst_adr", adr, 0);
    chk("rst_dat", dat, 0); chk("rst_ready", col_ready, 1); chk("rst_level", level, 0);
    model_reset();
    rst_n = 1'b1;
    wait_drain(200);
    idle_quiet(40);

    // Single full column lands in column 6
    push(5'h1F);
    @(negedge clk);
    chk("level_one", level, 1);
    col_valid = 1'b0;
    t = 0;
    while (level != 0 && t < 100) begin @(negedge clk); t++; end
    chk("pop_starts_burst", {stb, adr}, {1'b1, 4'd0});
    wait_drain(200);
    for (int r = 0; r < 5; r++) chk("full_col_row", last_dat[r], 8'h40);

    // Diagonal pattern over 7 steps
    for (int i = 0; i < 7; i++) push(diag[i]);
    release_col();
    wait_drain(400);
    for (int r = 0; r < 5; r++) chk("diag_row", last_dat[r], diag_rows[r]);

    // FIFO fill while the peripheral is stalled
    stall = 1'b1; chk_hold = 1'b0;
    push(5'h0A);
    release_col();
    t = 0;
    while (!stb && t < 100) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    chk("stall_hold", {stb, adr}, {1'b1, 4'd0});
    for (int i = 0; i < 8; i++) push(fill[i]);
    @(negedge clk);
    chk("full_level", level, 8);
    chk("full_ready", col_ready, 0);
    stall = 1'b0;
    push(5'h18);
    @(negedge clk);
    col_valid = 1'b0;
    chk("refill_level", level, 8);
    chk("refill_stb", stb, 1);
    wait_drain(1000);
    chk_hold = 1'b1;

    // Slow peripheral: tick during burst is kept pending, next step follows immediately
    wait_cfg = 3;
    push(5'h07);
    push(5'h19);
    release_col();
    t = 0;
    while (level != 0 && t < 300) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("restart_gap", last_gap, 1);
    wait_drain(300);
    idle_quiet(30);

    // Reset in the middle of a burst
    push(5'h15);
    release_col();
    t = 0;
    while (!(stb && adr == 4'd2 && !ack) && t < 200) begin @(negedge clk); t++; end
    chk("reached_row2", {stb, adr}, {1'b1, 4'd2});
    #1 rst_n = 1'b0;
    #1 chk("async_stb_drop", stb, 0);
    chk("async_adr_zero", adr, 0);
    model_reset();
    @(negedge clk);
    chk("mid_rst_level", level, 0);
    rst_n = 1'b1;
    wait_drain(300);
    for (int r = 0; r < 5; r++) chk("reblank_row", last_dat[r], 8'h00);
    chk("final_ready", col_ready, 1);
    chk("final_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/charlieplex_scroller.md
Name: charlieplex_scroller

Overview:
- Wishbone B4 master that drives the charlieplex screen peripheral, which holds 5 rows of 7 pixels.
- Accepts 5-bit column bitmaps on a valid/ready stream and buffers them in a small FIFO.
- Every TicksPerStep clocks it shifts one column into a 7-column window, scrolling right to left.
- After each shift it rewrites all 5 row registers of the screen peripheral over Wishbone.

Parameters:
- TicksPerStep, 1000000, clocks between scroll steps (>=2).
- Depth, 8, column FIFO depth (power of two, >=2).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- col_valid_i  in  1  column word offered.
- col_ready_o  out  1  FIFO can accept a column.
- col_data_i  in  5  column bitmap; bit r = pixel in row r.
- wb_we_o  out  1  write enable (always 1 while wb_stb_o=1, else 0).
- wb_stb_o  out  1  strobe/cycle request.
- wb_ack_i  in  1  peripheral acknowledge.
- wb_adr_o  out  4  row address 0..4.
- wb_dat_o  out  8  row pixels; bit c = column c, bit 7 = 0.
- wb_dat_i  in  8  unused; reduced into an unused signal.
- fifo_level_o  out  $clog2(Depth)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - FIFO empty; col_ready_o=1; fifo_level_o=0.
  - Window all zero; step counter=0; pending=0.
  - wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0.
  - FSM enters INIT.
- FIFO:
  - Push when col_valid_i && col_ready_o.
  - col_ready_o = (level != Depth), combinational from level.
  - No bypass: a push into an empty FIFO is poppable from the next cycle.
  - Simultaneous push and pop in the same cycle leaves level unchanged.
  - Pointers wrap modulo Depth.
- Step counter:
  - Free-running 0..TicksPerStep-1, wraps to 0.
  - tick = (counter == TicksPerStep-1).
  - Counts in every state.
- Pending flag:
  - Set on tick when the FSM is not IDLE.
  - A second tick while pending is already set is dropped.
  - Cleared when consumed.
- FSM states: INIT, IDLE, WRITE.
- INIT:
  - Entered from reset.
  - Writes rows 0..4 from the current window (all zero, so the screen is blanked).
  - Goes to IDLE after the ack on row 4.
- IDLE, step condition = (tick || pending) && FIFO non-empty:
  - Pop one column c_new.
  - Window shifts: w[k] <= w[k+1] for k=0..5, w[6] <= c_new; old w[0] is discarded.
  - Clear pending and go to WRITE with row=0.
- IDLE with (tick || pending) and FIFO empty:
  - No shift, no bus traffic.
  - pending is cleared; empty steps are not queued.
- WRITE, and INIT, bus cycle:
  - wb_stb_o=1, wb_we_o=1.
  - wb_adr_o=row.
  - wb_dat_o={1'b0, w[6][row], ..., w[0][row]}.
  - All held stable until wb_ack_i=1.
  - On ack: row+1; after row 4, wb_stb_o drops to 0 next cycle and the FSM returns to IDLE.
  - Exactly one write per row per step; ack sampled only while wb_stb_o=1.
- Window is modified only in IDLE, so every 5-row burst is a consistent snapshot.
- Latency:
  - Step taken at clock edge E drives wb_stb_o=1 with adr 0 from E.
  - With a combinational-ack peripheral, the burst is 5 consecutive cycles, stb low on the 6th.
  - Minimum step-to-idle is 6 cycles, so TicksPerStep>=7 avoids dropping ticks against a zero-wait peripheral.
- Reset asserted mid-burst: stb drops immediately (asynchronously); on release, INIT runs again and blanks the screen.
- Stalled peripheral (ack never arrives): stb held indefinitely; FIFO still accepts pushes until full.

Test Plan:
- Reset release, ack=stb, TicksPerStep=16 -> 5 writes adr 0..4, dat 0x00, then stb=0; no further traffic with an empty FIFO.
- Push 0x1F, then wait for a tick -> rows 0..4 all written 0x40; fifo_level_o goes 1->0.
- Push 0x01,0x02,0x04,0x08,0x10,0x1F,0x00, then run 7 steps -> final rows: r0=0x21, r1=0x22, r2=0x24, r3=0x28, r4=0x30 (diagonal plus column 5 full, column 6 blank).
- Push 9 columns with Depth=8 and no tick yet -> col_ready_o=0 after the 8th push; 9th held off; level=8; push accepted again the cycle after the first pop.
- Peripheral acks with 3 wait cycles and TicksPerStep=7 -> each write's adr/dat held 4 cycles; a tick during the burst sets pending; the next shift starts immediately after returning to IDLE; a second tick during the same burst is dropped.
- Assert rst_ni low while adr=2 is strobed -> stb=0 asynchronously; after release, the INIT burst writes 0x00 to rows 0..4; FIFO is empty.
